// File: rtl/uart_boot_ctrl_pkg.sv
// Shared definitions for the UART boot loader.
//   state_t    : loader/run sequencer state encoding
//   SYNC_BYTE  : frame start marker
//   ACK_BYTE   : response sent after a frame whose checksum matches
//   NAK_BYTE   : response sent after any frame error
//   in_frame() : true for the states in which the inter-byte timeout runs
package boot_pkg;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_CNT_L = 4'd1,
        ST_CNT_H = 4'd2,
        ST_INS_L = 4'd3,
        ST_INS_H = 4'd4,
        ST_CHK   = 4'd5,
        ST_ACK   = 4'd6,
        ST_ERR   = 4'd7,
        ST_DONE  = 4'd8,
        ST_RUN   = 4'd9
    } state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] ACK_BYTE  = 8'h06;
    localparam logic [7:0] NAK_BYTE  = 8'h15;

    function automatic logic in_frame(input state_t s);
        return (s == ST_CNT_L) || (s == ST_CNT_H) || (s == ST_INS_L) ||
               (s == ST_INS_H) || (s == ST_CHK);
    endfunction

endpackage

// File: rtl/uart_boot_ctrl_if.sv
// Byte and instruction-memory bus between the boot loader and its neighbours.
//   rx_byte/rx_valid       : byte stream from uart_rx (1-cycle strobe, no back-pressure)
//   tx_byte/tx_valid/tx_ready : response byte to uart_tx
//   imem_we/imem_addr/imem_wdata : instruction write port
// Handshake: tx_valid/tx_byte stay stable while tx_valid=1 and tx_ready=0; the byte
// is taken on the first rising CLK edge where tx_valid=1 and tx_ready=1. rx_valid has
// no ready: a byte is consumed (or ignored) in the cycle its strobe is high.
// master = boot loader side, slave = uart/memory side.
interface uart_boot_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic [7:0]        rx_byte;
    logic              rx_valid;
    logic [7:0]        tx_byte;
    logic              tx_valid;
    logic              tx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [15:0]       imem_wdata;

    modport master (
        input  rx_byte, rx_valid, tx_ready,
        output tx_byte, tx_valid, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        output rx_byte, rx_valid, tx_ready,
        input  tx_byte, tx_valid, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/uart_boot_ctrl_timeout.sv
// Inter-byte timeout counter.
//   CLK, RESET : clock, async active-low reset
//   clr        : restart from zero (a byte arrived)
//   en         : count while high; held at zero while low
//   expired    : counter has reached TIMEOUT_CYC-1 and was not cleared this cycle
module boot_timeout #(
    parameter int TIMEOUT_CYC = 500000
) (
    input  logic CLK,
    input  logic RESET,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            cnt <= '0;
        end else if (clr || !en) begin
            cnt <= '0;
        end else if (cnt != LAST) begin
            // Saturate: the FSM leaves the frame the cycle after expiry anyway.
            cnt <= cnt + CW'(1);
        end
    end

    assign expired = en && !clr && (cnt == LAST);
endmodule

// File: rtl/uart_boot_ctrl.sv
// Framed UART boot loader and CPU run sequencer.
// Frame: A5, CNT_L, CNT_H, {INS_L, INS_H} x CNT, CHK (little-endian),
// CHK = 8-bit sum of every byte after the sync byte.
//   CLK, RESET  : clock, async active-low reset
//   reload_n    : sync active-low abort back to IDLE (highest priority)
//   run_start   : 1-cycle request, honoured only in DONE
//   bus         : rx byte stream, tx response handshake, imem write port
//   cpu_rst     : core reset, low only in DONE/RUN
//   cpu_run     : core write enable, high only in RUN
//   load_err    : sticky error, cleared by a new sync byte or reload_n
//   busy        : high from CNT_L through ACK
//   dbg_state   : current FSM state
module uart_boot_ctrl
    import boot_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int TIMEOUT_CYC = 500000
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                reload_n,
    input  logic                run_start,
    uart_boot_ctrl_if.master    bus,
    output logic                cpu_rst,
    output logic                cpu_run,
    output logic                load_err,
    output logic                busy,
    output state_t              dbg_state
);
    // 17 bits holds both a 16-bit count and DEPTH for ADDR_W up to 16.
    localparam int CW = 17;
    localparam logic [CW-1:0] DEPTH = CW'(2 ** ADDR_W);

    state_t            state_q, state_d;
    logic [7:0]        lo_q;
    logic [15:0]       cnt_q;
    logic [ADDR_W-1:0] idx_q;
    logic [7:0]        sum_q;
    logic              imem_we_q;
    logic [ADDR_W-1:0] imem_addr_q;
    logic [15:0]       imem_wdata_q;
    logic              load_err_q;
    logic              expired;

    logic [15:0] word_in;
    logic        last_ins;
    logic        tx_valid_c;
    logic [7:0]  tx_byte_c;

    assign word_in  = {bus.rx_byte, lo_q};
    assign last_ins = ((CW'(idx_q) + CW'(1)) == CW'(cnt_q));

    boot_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
        .CLK     (CLK),
        .RESET   (RESET),
        .clr     (bus.rx_valid),
        .en      (in_frame(state_q)),
        .expired (expired)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        tx_valid_c = 1'b0;
        tx_byte_c  = 8'h00;
        cpu_rst    = 1'b1;
        cpu_run    = 1'b0;
        busy       = 1'b0;

        if (!reload_n) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (bus.rx_valid && bus.rx_byte == SYNC_BYTE) state_d = ST_CNT_L;
                ST_CNT_L: if (bus.rx_valid) state_d = ST_CNT_H;
                ST_CNT_H: if (bus.rx_valid) begin
                    if ({1'b0, word_in} > DEPTH) state_d = ST_ERR;
                    else if (word_in == 16'd0)   state_d = ST_CHK;
                    else                         state_d = ST_INS_L;
                end
                ST_INS_L: if (bus.rx_valid) state_d = ST_INS_H;
                ST_INS_H: if (bus.rx_valid) state_d = last_ins ? ST_CHK : ST_INS_L;
                ST_CHK:   if (bus.rx_valid) state_d = (bus.rx_byte == sum_q) ? ST_ACK : ST_ERR;
                ST_ACK:   if (bus.tx_ready) state_d = ST_DONE;
                ST_ERR:   if (bus.tx_ready) state_d = ST_IDLE;
                ST_DONE:  if (run_start) state_d = ST_RUN;
                ST_RUN:   state_d = ST_RUN;
                default:  state_d = ST_IDLE;
            endcase
            // A byte landing in the expiry cycle takes precedence.
            if (in_frame(state_q) && !bus.rx_valid && expired) state_d = ST_ERR;
        end

        case (state_q)
            ST_ACK: begin tx_valid_c = 1'b1; tx_byte_c = ACK_BYTE; end
            ST_ERR: begin tx_valid_c = 1'b1; tx_byte_c = NAK_BYTE; end
            ST_DONE: cpu_rst = 1'b0;
            ST_RUN: begin cpu_rst = 1'b0; cpu_run = 1'b1; end
            default: ;
        endcase
        busy = (state_q >= ST_CNT_L) && (state_q <= ST_ACK);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            lo_q         <= 8'h00;
            cnt_q        <= 16'h0000;
            idx_q        <= '0;
            sum_q        <= 8'h00;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= 16'h0000;
            load_err_q   <= 1'b0;
        end else begin
            imem_we_q <= 1'b0;
            if (!reload_n) begin
                load_err_q <= 1'b0;
            end else begin
                if (state_d == ST_ERR && state_q != ST_ERR) load_err_q <= 1'b1;
                if (bus.rx_valid) begin
                    case (state_q)
                        ST_IDLE: if (bus.rx_byte == SYNC_BYTE) begin
                            sum_q      <= 8'h00;
                            load_err_q <= 1'b0;
                        end
                        ST_CNT_L, ST_INS_L: begin
                            lo_q  <= bus.rx_byte;
                            sum_q <= sum_q + bus.rx_byte;
                        end
                        ST_CNT_H: begin
                            cnt_q <= word_in;
                            idx_q <= '0;
                            sum_q <= sum_q + bus.rx_byte;
                        end
                        ST_INS_H: begin
                            imem_we_q    <= 1'b1;
                            imem_addr_q  <= idx_q;
                            imem_wdata_q <= word_in;
                            idx_q        <= idx_q + ADDR_W'(1);
                            sum_q        <= sum_q + bus.rx_byte;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign bus.tx_valid   = tx_valid_c;
    assign bus.tx_byte    = tx_byte_c;
    assign bus.imem_we    = imem_we_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_wdata = imem_wdata_q;
    assign load_err       = load_err_q;
    assign dbg_state      = state_q;
endmodule
